// File: rtl/band_gain_sched.sv
// band_gain_sched: time-multiplexed gain scheduler. One signed 17x17
// multiplier squares the band pots, scales the ten band samples and applies
// volume in an 18-cycle pass. It also owns the amplifier-enable timeout.
module band_gain_sched #(
  parameter int unsigned AMP_TO = 4800
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] lp_L,
  input  logic signed [15:0] b1_L,
  input  logic signed [15:0] b2_L,
  input  logic signed [15:0] b3_L,
  input  logic signed [15:0] hp_L,
  input  logic signed [15:0] lp_R,
  input  logic signed [15:0] b1_R,
  input  logic signed [15:0] b2_R,
  input  logic signed [15:0] b3_R,
  input  logic signed [15:0] hp_R,
  input  logic        [11:0] POT_LP,
  input  logic        [11:0] POT_B1,
  input  logic        [11:0] POT_B2,
  input  logic        [11:0] POT_B3,
  input  logic        [11:0] POT_HP,
  input  logic        [11:0] POT_VOL,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rht_out,
  output logic               out_vld,
  output logic               busy,
  output logic               ovr,
  output logic               amp_on
);

  localparam int unsigned CW = $clog2(AMP_TO + 1);

  typedef enum logic [2:0] {IDLE, CAP, SQR, MAC, VOL} state_t;

  state_t             state, state_nxt;
  logic signed [15:0] smp [10];
  logic        [11:0] pot [5];
  logic        [11:0] gain [5];
  logic        [11:0] vol;
  logic        [3:0]  idx;
  logic        [2:0]  band;
  logic signed [18:0] acc, acc_nxt;
  logic signed [15:0] ch_l, ch_r, vol_l;
  logic signed [16:0] mul_a, mul_b;
  logic signed [33:0] prod, p11, p12, acc_ext;
  logic signed [15:0] term, vres, ch_sat;
  logic               last, accept;
  logic [CW-1:0]      cnt;

  function automatic logic signed [15:0] sat16(input logic signed [33:0] x);
    if (x > 34'sd32767)       return 16'sh7fff;
    else if (x < -34'sd32768) return 16'sh8000;
    else                      return x[15:0];
  endfunction

  // Band index within the current channel and pass-completion detection.
  // The DONE output load is folded into the final VOL edge so busy drops
  // there and a start on that same edge is accepted back-to-back.
  always_comb begin
    band   = (idx >= 4'd5) ? 3'(idx - 4'd5) : idx[2:0];
    last   = (state == VOL) && (idx == 4'd1);
    accept = start && ((state == IDLE) || last);
    busy   = (state != IDLE);
  end

  // Shared multiplier operand select.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      SQR: begin
        mul_a = {5'b0, pot[band]};
        mul_b = {5'b0, pot[band]};
      end
      MAC: begin
        mul_a = {smp[idx][15], smp[idx]};
        mul_b = {5'b0, gain[band]};
      end
      VOL: begin
        mul_a = (idx == 4'd0) ? {ch_l[15], ch_l} : {ch_r[15], ch_r};
        mul_b = {5'b0, vol};
      end
      default: ;
    endcase
  end

  // Product scaling, saturation and accumulator update.
  always_comb begin
    prod    = mul_a * mul_b;
    p11     = prod >>> 11;
    p12     = prod >>> 12;
    term    = sat16(p11);
    vres    = sat16(p12);
    acc_nxt = (band == 3'd0) ? {{3{term[15]}}, term} : acc + {{3{term[15]}}, term};
    acc_ext = {{15{acc_nxt[18]}}, acc_nxt};
    ch_sat  = sat16(acc_ext);
  end

  // Next-state logic for the pass sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CAP;
      CAP:  state_nxt = SQR;
      SQR:  if (idx == 4'd4) state_nxt = MAC;
      MAC:  if (idx == 4'd9) state_nxt = VOL;
      VOL:  if (last) state_nxt = accept ? CAP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture, datapath registers, outputs and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp     <= '{default: '0};
      pot     <= '{default: '0};
      gain    <= '{default: '0};
      vol     <= '0;
      idx     <= '0;
      acc     <= '0;
      ch_l    <= '0;
      ch_r    <= '0;
      vol_l   <= '0;
      lft_out <= '0;
      rht_out <= '0;
      out_vld <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      out_vld <= last;
      if (start && !accept) ovr <= 1'b1;
      if (accept) begin
        smp <= '{lp_L, b1_L, b2_L, b3_L, hp_L, lp_R, b1_R, b2_R, b3_R, hp_R};
        pot <= '{POT_LP, POT_B1, POT_B2, POT_B3, POT_HP};
        vol <= POT_VOL;
      end
      case (state)
        CAP: idx <= '0;
        SQR: begin
          gain[band] <= prod[23:12];
          idx        <= (idx == 4'd4) ? 4'd0 : idx + 4'd1;
        end
        MAC: begin
          acc <= acc_nxt;
          if (idx == 4'd4) ch_l <= ch_sat;
          if (idx == 4'd9) ch_r <= ch_sat;
          idx <= (idx == 4'd9) ? 4'd0 : idx + 4'd1;
        end
        VOL: begin
          if (idx == 4'd0) vol_l <= vres;
          if (last) begin
            lft_out <= vol_l;
            rht_out <= vres;
          end
          idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Amplifier enable: set by each result, cleared when no start has been
  // seen for AMP_TO clocks; a coincident result keeps it on.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      amp_on <= 1'b0;
    end else begin
      if (start)                 cnt <= '0;
      else if (cnt != CW'(AMP_TO)) cnt <= cnt + 1'b1;
      if (last)                                        amp_on <= 1'b1;
      else if (!start && (cnt == CW'(AMP_TO - 1)))     amp_on <= 1'b0;
    end
  end

endmodule

// File: tb/tb_band_gain_sched.sv
// Self-checking bench for band_gain_sched: directed cases plus randomized
// passes scored against an arithmetic reference model via a result queue.
module tb_band_gain_sched;

  logic clk = 1'b0;
  logic rst, start;
  logic signed [15:0] sl [5];
  logic signed [15:0] sr [5];
  logic        [11:0] pt [5];
  logic        [11:0] pv;
  logic signed [15:0] lft_out, rht_out;
  logic out_vld, busy, ovr, amp_on;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int s, s2;

  typedef struct {
    longint l;
    longint r;
    int     due;
  } exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  band_gain_sched #(.AMP_TO(64)) dut (
    .clk(clk), .rst(rst), .start(start),
    .lp_L(sl[0]), .b1_L(sl[1]), .b2_L(sl[2]), .b3_L(sl[3]), .hp_L(sl[4]),
    .lp_R(sr[0]), .b1_R(sr[1]), .b2_R(sr[2]), .b3_R(sr[3]), .hp_R(sr[4]),
    .POT_LP(pt[0]), .POT_B1(pt[1]), .POT_B2(pt[2]), .POT_B3(pt[3]), .POT_HP(pt[4]),
    .POT_VOL(pv),
    .lft_out(lft_out), .rht_out(rht_out), .out_vld(out_vld),
    .busy(busy), .ovr(ovr), .amp_on(amp_on)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint sat(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Floor division for positive divisor.
  function automatic longint fdiv(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // Reference: gains from squared pots, saturated band terms, channel sum,
  // then volume, all from the currently driven inputs.
  function automatic longint chan(input bit right);
    longint sum, g, x;
    sum = 0;
    for (int b = 0; b < 5; b++) begin
      g = (longint'(pt[b]) * longint'(pt[b])) / 4096;
      x = right ? longint'(sr[b]) : longint'(sl[b]);
      sum += sat(fdiv(x * g, 2048));
    end
    return sat(fdiv(sat(sum) * longint'(pv), 4096));
  endfunction

  // Result scoreboard: every out_vld must match the oldest accepted pass.
  always @(negedge clk) begin
    if (out_vld) begin
      if (q.size() == 0) check("unexpected_vld", 1, 0);
      else begin
        e = q.pop_front();
        check("lft_out", lft_out, e.l);
        check("rht_out", rht_out, e.r);
        check("latency", cyc, e.due);
      end
    end
  end

  // Called at a negedge; start is sampled on the following edge.
  task automatic send_start(input bit acc_exp);
    exp_t x;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (acc_exp) begin
      x.l = chan(1'b0);
      x.r = chan(1'b1);
      x.due = cyc + 18;
      q.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_all(input logic signed [15:0] l, input logic signed [15:0] r,
                         input logic [11:0] p, input logic [11:0] v);
    for (int b = 0; b < 5; b++) begin
      sl[b] = l;
      sr[b] = r;
      pt[b] = p;
    end
    pv = v;
  endtask

  task automatic set_rand();
    for (int b = 0; b < 5; b++) begin
      sl[b] = 16'($urandom);
      sr[b] = 16'($urandom);
      pt[b] = 12'($urandom);
    end
    pv = 12'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", q.size(), 0);
    @(negedge clk);
    check("vld_pulse", out_vld, 0);
  endtask

  task automatic wait_until(input int edge_idx);
    while (cyc < edge_idx) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    set_all(16'sd0, 16'sd0, 12'd0, 12'd0);
    repeat (3) @(negedge clk);
    check("rst_lft", lft_out, 0);
    check("rst_rht", rht_out, 0);
    check("rst_vld", out_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", ovr, 0);
    check("rst_amp", amp_on, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic gain: only LP pot open, full volume.
    set_all(16'sd1000, -16'sd1000, 12'd0, 12'd4095);
    pt[0] = 12'd4095;
    send_start(1'b1);
    check("busy_run", busy, 1);
    drain();
    check("basic_l", lft_out, 1998);
    check("basic_r", rht_out, -2000);
    check("busy_idle", busy, 0);

    // Saturation both polarities.
    set_all(16'sd32767, 16'sd32767, 12'd4095, 12'd4095);
    send_start(1'b1);
    drain();
    check("satp_l", lft_out, 32759);
    check("satp_r", rht_out, 32759);
    set_all(-16'sd32768, -16'sd32768, 12'd4095, 12'd4095);
    send_start(1'b1);
    drain();
    check("satn_l", lft_out, -32760);
    check("satn_r", rht_out, -32760);
    check("ovr_clean", ovr, 0);

    // Overrun at +5, then a start on the completing edge is accepted.
    set_rand();
    send_start(1'b1);
    repeat (4) @(negedge clk);
    set_rand();
    send_start(1'b0);
    check("ovr_set", ovr, 1);
    repeat (12) @(negedge clk);
    set_rand();
    send_start(1'b1);
    drain();
    check("ovr_sticky", ovr, 1);

    // Reset mid-pass abandons the pass.
    set_rand();
    send_start(1'b1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("mid_lft", lft_out, 0);
    check("mid_rht", rht_out, 0);
    check("mid_busy", busy, 0);
    check("mid_ovr", ovr, 0);
    check("mid_amp", amp_on, 0);
    repeat (30) @(negedge clk);
    check("mid_quiet_lft", lft_out, 0);
    set_rand();
    send_start(1'b1);
    drain();

    // Back-to-back passes every 19 clocks, B2 pot changing each pass.
    set_rand();
    for (int p = 0; p < 10; p++) begin
      pt[2] = 12'($urandom);
      send_start(1'b1);
      if (p < 9) repeat (18) @(negedge clk);
    end
    drain();
    check("b2b_ovr", ovr, 0);

    // Amp timeout with AMP_TO = 64.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_rand();
    send_start(1'b1);
    s = cyc;
    wait_until(s + 17);
    check("amp_before_vld", amp_on, 0);
    wait_until(s + 18);
    check("amp_at_vld", amp_on, 1);
    wait_until(s + 63);
    check("amp_hold", amp_on, 1);
    wait_until(s + 64);
    check("amp_timeout", amp_on, 0);
    drain();

    // A (rejected) start before timeout restarts the count.
    set_rand();
    send_start(1'b1);
    s2 = cyc;
    wait_until(s2 + 4);
    send_start(1'b0);
    wait_until(s2 + 64);
    check("amp_restart_hold", amp_on, 1);
    wait_until(s2 + 68);
    check("amp_restart_hold2", amp_on, 1);
    wait_until(s2 + 69);
    check("amp_restart_off", amp_on, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
